// File: rtl/regfile_we_decoder_if.sv
// Bus bundle for the register-file write-enable decoder: the decode request,
// the clear-sweep control and the registered strobe/status outputs.
interface regfile_we_decoder_if #(
  parameter int ADDR_W = 5
) ();

  logic                     en;
  logic [ADDR_W-1:0]        addr;
  logic                     clr_start;
  logic [(2**ADDR_W)-1:0]   out;
  logic                     clr_busy;
  logic                     clr_done;

  // Requester side: issues writes and clear requests, observes strobes.
  modport master (
    output en, addr, clr_start,
    input  out, clr_busy, clr_done
  );

  // Decoder side: consumes requests, drives registered strobes.
  modport slave (
    input  en, addr, clr_start,
    output out, clr_busy, clr_done
  );

endinterface

// File: rtl/regfile_we_decoder.sv
// Registered one-hot write-enable decoder for the CPU register file.
// IDLE decodes en/addr into a single strobe one cycle later; a clear request
// walks a strobe across every writable register, one per cycle, so the file
// can zero itself after reset. The optional zero register (top index) is
// never strobed.
module regfile_we_decoder #(
  parameter int ADDR_W      = 5,
  parameter bit ZERO_REG_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_we_decoder_if.slave  bus
);

  localparam int NUM_OUT = 2**ADDR_W;
  localparam int LAST    = (ZERO_REG_EN == 1'b1) ? (NUM_OUT - 2) : (NUM_OUT - 1);

  localparam logic [ADDR_W-1:0]  LAST_IDX = ADDR_W'(LAST);
  localparam logic [ADDR_W-1:0]  XZR_IDX  = ADDR_W'(NUM_OUT - 1);
  localparam logic [ADDR_W-1:0]  CNT_ONE  = ADDR_W'(1);
  localparam logic [NUM_OUT-1:0] ONE_HOT0 = NUM_OUT'(1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic [ADDR_W-1:0]    cnt_r;
  logic [ADDR_W-1:0]    cnt_s;
  logic [NUM_OUT-1:0]   out_r;
  logic [NUM_OUT-1:0]   out_s;
  logic                 busy_r;
  logic                 busy_s;
  logic                 done_r;
  logic                 done_s;
  logic                 addr_is_xzr_s;

  // The zero register is only special when it is enabled.
  assign addr_is_xzr_s = (ZERO_REG_EN == 1'b1) && (bus.addr == XZR_IDX);

  // Next-state and next-output logic; every register is recomputed each edge.
  always_comb begin
    state_s = IDLE;
    cnt_s   = '0;
    out_s   = '0;
    busy_s  = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.clr_start) begin
          // Clear has priority over a write sampled on the same edge.
          state_s = CLEAR;
          cnt_s   = '0;
          out_s   = ONE_HOT0;
          busy_s  = 1'b1;
        end else if (bus.en && !addr_is_xzr_s) begin
          out_s = ONE_HOT0 << bus.addr;
        end else begin
          out_s = '0;
        end
      end
      CLEAR: begin
        if (cnt_r == LAST_IDX) begin
          // Strobe LAST was shown this cycle: leave the sweep and pulse done.
          state_s = IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = CLEAR;
          cnt_s   = cnt_r + CNT_ONE;
          out_s   = ONE_HOT0 << (cnt_r + CNT_ONE);
          busy_s  = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, sweep counter and output registers; reset aborts any sweep.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      out_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      out_r   <= out_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign bus.out      = out_r;
  assign bus.clr_busy = busy_r;
  assign bus.clr_done = done_r;

endmodule
